// File: rtl/player1_controller_if.sv
// Player-1 button inputs and the action/position outputs that feed player1_sprite.
interface player1_controller_if;
    logic       btn_left;
    logic       btn_right;
    logic       btn_punch;
    logic       btn_kick;
    logic       btn_block;
    logic       btn_jump;
    logic [6:0] player1_inputs;
    logic [9:0] player1_x;
    logic       action_busy;

    modport master (
        output btn_left, btn_right, btn_punch, btn_kick, btn_block, btn_jump,
        input  player1_inputs, player1_x, action_busy
    );

    modport slave (
        input  btn_left, btn_right, btn_punch, btn_kick, btn_block, btn_jump,
        output player1_inputs, player1_x, action_busy
    );
endinterface

// File: rtl/player1_controller.sv
// Player-1 controller: button sync/debounce, one-hot action FSM with timed
// attack/jump states, and rate-divided horizontal movement clamped to the arena.
module player1_controller #(
    parameter int DEBOUNCE_MAX  = 500_000,
    parameter int ATTACK_CYCLES = 25_000_000,
    parameter int JUMP_CYCLES   = 50_000_000,
    parameter int STEP_DIV      = 1_000_000,
    parameter int STEP_PX       = 2,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 512,
    parameter int X_INIT        = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    player1_controller_if.slave   bus
);

    localparam int DEB_W   = $clog2(DEBOUNCE_MAX + 1);
    localparam int DUR_MAX = (JUMP_CYCLES > ATTACK_CYCLES) ? JUMP_CYCLES : ATTACK_CYCLES;
    localparam int DUR_W   = $clog2(DUR_MAX + 1);
    localparam int STEP_W  = $clog2(STEP_DIV + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEBOUNCE_MAX - 1);
    localparam logic [DUR_W-1:0]  ATTACK_LOAD = DUR_W'(ATTACK_CYCLES - 1);
    localparam logic [DUR_W-1:0]  JUMP_LOAD   = DUR_W'(JUMP_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(STEP_DIV - 1);
    localparam logic signed [10:0] STEP_S     = 11'(STEP_PX);
    localparam logic signed [10:0] X_MIN_S    = 11'(X_MIN);
    localparam logic [10:0]        STEP_U     = 11'(STEP_PX);
    localparam logic [10:0]        X_MAX_U    = 11'(X_MAX);
    localparam logic [9:0]         X_MIN_10   = 10'(X_MIN);
    localparam logic [9:0]         X_MAX_10   = 10'(X_MAX);
    localparam logic [9:0]         X_INIT_10  = 10'(X_INIT);

    // Button bit positions inside the packed vectors below
    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_PUNCH = 2;
    localparam int B_KICK  = 3;
    localparam int B_BLOCK = 4;
    localparam int B_JUMP  = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WALK_L = 3'd1,
        ST_WALK_R = 3'd2,
        ST_BLOCK  = 3'd3,
        ST_PUNCH  = 3'd4,
        ST_KICK   = 3'd5,
        ST_JUMP   = 3'd6
    } state_t;

    function automatic logic [6:0] state_onehot(input state_t s);
        case (s)
            ST_IDLE:   return 7'b0000001;
            ST_WALK_L: return 7'b0000010;
            ST_WALK_R: return 7'b0000100;
            ST_PUNCH:  return 7'b0001000;
            ST_KICK:   return 7'b0010000;
            ST_BLOCK:  return 7'b0100000;
            ST_JUMP:   return 7'b1000000;
            default:   return 7'b0000001;
        endcase
    endfunction

    logic [5:0]        btn_raw_s;
    logic [5:0]        sync1_r;
    logic [5:0]        sync2_r;
    logic [5:0]        deb_r;
    logic [2:0]        deb_prev_r;
    logic [DEB_W-1:0]  deb_cnt_r [6];
    logic              punch_edge_s;
    logic              kick_edge_s;
    logic              jump_edge_s;

    state_t            state_r;
    state_t            state_next_s;
    logic [DUR_W-1:0]  dur_r;
    logic [DUR_W-1:0]  dur_next_s;
    logic [6:0]        onehot_next_s;
    logic [6:0]        player1_inputs_r;
    logic              action_busy_r;

    logic [STEP_W-1:0] step_cnt_r;
    logic              step_tick_s;
    logic [9:0]        x_r;
    logic [9:0]        x_next_s;
    logic signed [10:0] x_left_s;
    logic [10:0]       x_right_s;

    assign btn_raw_s = {bus.btn_jump, bus.btn_block, bus.btn_kick,
                        bus.btn_punch, bus.btn_right, bus.btn_left};

    // Two-flop synchronizer plus per-button stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= 6'd0;
            sync2_r    <= 6'd0;
            deb_r      <= 6'd0;
            deb_prev_r <= 3'd0;
            for (int i = 0; i < 6; i++) begin
                deb_cnt_r[i] <= {DEB_W{1'b0}};
            end
        end else begin
            sync1_r    <= btn_raw_s;
            sync2_r    <= sync1_r;
            deb_prev_r <= {deb_r[B_JUMP], deb_r[B_KICK], deb_r[B_PUNCH]};
            for (int i = 0; i < 6; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    deb_cnt_r[i] <= {DEB_W{1'b0}};
                end else if (deb_cnt_r[i] == DEB_LAST) begin
                    deb_r[i]     <= sync2_r[i];
                    deb_cnt_r[i] <= {DEB_W{1'b0}};
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + 1'b1;
                end
            end
        end
    end

    assign punch_edge_s = deb_r[B_PUNCH] & ~deb_prev_r[0];
    assign kick_edge_s  = deb_r[B_KICK]  & ~deb_prev_r[1];
    assign jump_edge_s  = deb_r[B_JUMP]  & ~deb_prev_r[2];

    // Next-state: timed states count down, free states re-arbitrate every cycle
    always_comb begin
        state_next_s = state_r;
        dur_next_s   = dur_r;
        case (state_r)
            ST_PUNCH, ST_KICK, ST_JUMP: begin
                if (dur_r != {DUR_W{1'b0}}) begin
                    dur_next_s = dur_r - 1'b1;
                end else begin
                    dur_next_s = {DUR_W{1'b0}};
                end
            end
            default: begin
                dur_next_s = dur_r;
            end
        endcase

        // Edges seen while an action is still running never reach this arbitration
        if ((state_r != ST_PUNCH && state_r != ST_KICK && state_r != ST_JUMP) ||
            dur_r == {DUR_W{1'b0}}) begin
            if (jump_edge_s) begin
                state_next_s = ST_JUMP;
                dur_next_s   = JUMP_LOAD;
            end else if (punch_edge_s) begin
                state_next_s = ST_PUNCH;
                dur_next_s   = ATTACK_LOAD;
            end else if (kick_edge_s) begin
                state_next_s = ST_KICK;
                dur_next_s   = ATTACK_LOAD;
            end else if (deb_r[B_BLOCK]) begin
                state_next_s = ST_BLOCK;
            end else if (deb_r[B_LEFT] && !deb_r[B_RIGHT]) begin
                state_next_s = ST_WALK_L;
            end else if (deb_r[B_RIGHT] && !deb_r[B_LEFT]) begin
                state_next_s = ST_WALK_R;
            end else begin
                state_next_s = ST_IDLE;
            end
        end else begin
            state_next_s = state_r;
        end
    end

    assign onehot_next_s = state_onehot(state_next_s);

    // State, duration counter and registered action outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            dur_r            <= {DUR_W{1'b0}};
            player1_inputs_r <= 7'b0000001;
            action_busy_r    <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            dur_r            <= dur_next_s;
            player1_inputs_r <= onehot_next_s;
            action_busy_r    <= onehot_next_s[3] | onehot_next_s[4] | onehot_next_s[6];
        end
    end

    assign step_tick_s = (step_cnt_r == STEP_LAST);

    // Free-running movement rate divider
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_r <= {STEP_W{1'b0}};
        end else if (step_tick_s) begin
            step_cnt_r <= {STEP_W{1'b0}};
        end else begin
            step_cnt_r <= step_cnt_r + 1'b1;
        end
    end

    // 11-bit arithmetic keeps a step past either edge from wrapping
    assign x_left_s  = $signed({1'b0, x_r}) - STEP_S;
    assign x_right_s = {1'b0, x_r} + STEP_U;

    // Position update, using the pre-transition state on a tick
    always_comb begin
        x_next_s = x_r;
        if (step_tick_s) begin
            case (state_r)
                ST_WALK_L: x_next_s = (x_left_s < X_MIN_S) ? X_MIN_10 : x_left_s[9:0];
                ST_WALK_R: x_next_s = (x_right_s > X_MAX_U) ? X_MAX_10 : x_right_s[9:0];
                default:   x_next_s = x_r;
            endcase
        end else begin
            x_next_s = x_r;
        end
    end

    // Position register
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r <= X_INIT_10;
        end else begin
            x_r <= x_next_s;
        end
    end

    assign bus.player1_inputs = player1_inputs_r;
    assign bus.player1_x      = x_r;
    assign bus.action_busy    = action_busy_r;

endmodule

// File: tb/tb_player1_controller.sv
// Bench for player1_controller: directed vector table, hand-timed corner
// sequences and randomized buttons, all checked against a behavioural model.
module tb_player1_controller;

    localparam int DM = 4;
    localparam int AC = 8;
    localparam int JC = 16;
    localparam int SD = 4;
    localparam int SP = 2;
    localparam int XMIN = 0;
    localparam int XMAX = 20;
    localparam int XINIT = 10;

    logic clk;
    logic rst;
    player1_controller_if bus();

    player1_controller #(
        .DEBOUNCE_MAX(DM), .ATTACK_CYCLES(AC), .JUMP_CYCLES(JC), .STEP_DIV(SD),
        .STEP_PX(SP), .X_MIN(XMIN), .X_MAX(XMAX), .X_INIT(XINIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total;
    int bad;
    logic [5:0] btn;   // {jump, block, kick, punch, right, left}

    // Model: action 0 idle,1 left,2 right,3 punch,4 kick,5 block,6 jump
    bit hist [6][DM+1];   // raw samples of the last DM+1 edges, [0] newest
    bit m_deb [6];
    bit m_debd [6];
    int m_state;
    int m_rem;
    int m_phase;
    int m_x;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_deb[i]  = 1'b0;
            m_debd[i] = 1'b0;
            for (int k = 0; k <= DM; k++) hist[i][k] = 1'b0;
        end
        m_state = 0;
        m_rem   = 0;
        m_phase = 0;
        m_x     = XINIT;
    endtask

    task automatic model_step();
        bit je, pe, ke, lv, rv, bv, flip;
        if (rst) begin
            model_reset();
        end else begin
            je = m_deb[5] && !m_debd[5];
            pe = m_deb[2] && !m_debd[2];
            ke = m_deb[3] && !m_debd[3];
            lv = m_deb[0];
            rv = m_deb[1];
            bv = m_deb[4];
            if (m_phase == SD - 1) begin
                if (m_state == 1) m_x = (m_x - SP < XMIN) ? XMIN : m_x - SP;
                else if (m_state == 2) m_x = (m_x + SP > XMAX) ? XMAX : m_x + SP;
            end
            m_phase = (m_phase + 1) % SD;
            if ((m_state == 3 || m_state == 4 || m_state == 6) && m_rem > 1) begin
                m_rem--;
            end else if (je) begin
                m_state = 6; m_rem = JC;
            end else if (pe) begin
                m_state = 3; m_rem = AC;
            end else if (ke) begin
                m_state = 4; m_rem = AC;
            end else if (bv) begin
                m_state = 5;
            end else if (lv && !rv) begin
                m_state = 1;
            end else if (rv && !lv) begin
                m_state = 2;
            end else begin
                m_state = 0;
            end
            // A level changes once DM consecutive synchronized samples disagree with it
            for (int i = 0; i < 6; i++) begin
                flip = 1'b1;
                for (int k = 1; k <= DM; k++) if (hist[i][k] == m_deb[i]) flip = 1'b0;
                m_debd[i] = m_deb[i];
                if (flip) m_deb[i] = !m_deb[i];
                for (int k = DM; k >= 1; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = btn[i];
            end
        end
    endtask

    task automatic tick();
        bus.btn_left  = btn[0];
        bus.btn_right = btn[1];
        bus.btn_punch = btn[2];
        bus.btn_kick  = btn[3];
        bus.btn_block = btn[4];
        bus.btn_jump  = btn[5];
        model_step();
        @(posedge clk);
        #1;
        check("model_inputs", int'(bus.player1_inputs), 1 << m_state);
        check("model_x", int'(bus.player1_x), m_x);
        check("model_busy", int'(bus.action_busy),
              (m_state == 3 || m_state == 4 || m_state == 6) ? 1 : 0);
    endtask

    typedef struct {
        logic [5:0] btn;
        int         cycles;
        int         exp_inputs;
        int         exp_x;      // negative: position not checked
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{6'b000000, 10, 1,  10};
        tbl[1] = '{6'b000010, 60, 4,  20};
        tbl[2] = '{6'b000000, 12, 1,  20};
        tbl[3] = '{6'b000001, 60, 2,  0};
        tbl[4] = '{6'b000011, 20, 1,  0};
        tbl[5] = '{6'b000000, 12, 1,  0};
        tbl[6] = '{6'b000010, 30, 4,  -1};
        tbl[7] = '{6'b010001, 20, 32, -1};
        tbl[8] = '{6'b000000, 12, 1,  -1};

        total = 0;
        bad   = 0;
        btn   = 6'b000000;
        rst   = 1'b1;
        model_reset();
        repeat (3) tick();
        check("reset_inputs", int'(bus.player1_inputs), 1);
        check("reset_x", int'(bus.player1_x), 10);
        check("reset_busy", int'(bus.action_busy), 0);
        rst = 1'b0;

        // Bounce: right toggles every 2 cycles and never settles
        for (int i = 0; i < 40; i++) begin
            btn[1] = ((i >> 1) & 1) != 0;
            tick();
            check("bounce_inputs", int'(bus.player1_inputs), 1);
            check("bounce_x", int'(bus.player1_x), 10);
        end

        for (int v = 0; v < 9; v++) begin
            btn = tbl[v].btn;
            repeat (tbl[v].cycles) tick();
            check("tbl_inputs", int'(bus.player1_inputs), tbl[v].exp_inputs);
            if (tbl[v].exp_x >= 0) check("tbl_x", int'(bus.player1_x), tbl[v].exp_x);
        end

        // Press-to-walk latency is exactly 7 cycles
        btn = 6'b000010;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("walk_latency", int'(bus.player1_inputs), (k == 7) ? 4 : 1);
        end
        btn = 6'b000000;
        repeat (12) tick();

        // Punch window: 8 cycles, kick inside is ignored, held left wins at exit
        btn = 6'b000100;
        repeat (7) tick();
        check("punch_start", int'(bus.player1_inputs), 8);
        check("punch_busy", int'(bus.action_busy), 1);
        btn = 6'b001101;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("punch_hold", int'(bus.player1_inputs), 8);
        end
        tick();
        check("punch_exit", int'(bus.player1_inputs), 2);
        check("punch_exit_busy", int'(bus.action_busy), 0);
        btn = 6'b000000;
        repeat (12) tick();

        // Simultaneous jump and punch edges: jump wins for 16 cycles
        btn = 6'b100100;
        repeat (7) tick();
        check("jump_start", int'(bus.player1_inputs), 64);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check("jump_hold", int'(bus.player1_inputs), 64);
        end
        tick();
        check("jump_exit", int'(bus.player1_inputs), 1);
        btn = 6'b000000;
        repeat (12) tick();

        // Reset during jump cycle 5
        btn = 6'b100000;
        repeat (7) tick();
        check("jump2_start", int'(bus.player1_inputs), 64);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("midjump_rst_inputs", int'(bus.player1_inputs), 1);
        check("midjump_rst_x", int'(bus.player1_x), 10);
        check("midjump_rst_busy", int'(bus.action_busy), 0);
        rst = 1'b0;
        btn = 6'b000000;

        // Randomized button patterns with occasional resets
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 1) == 0) btn = 6'($urandom_range(0, 3));
            else btn = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 20)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/player1_controller.md
# player1_controller

Upstream stage of `player1_sprite`. It turns the six raw player-1 push-buttons into the 7-bit `player1_inputs` action vector that selects the sprite and its animation. It also maintains the player's horizontal screen position, `player1_x`, used by the VGA address logic. Internally it synchronizes and debounces every button, runs a one-hot action FSM with timed attack and jump states, and moves the player at a divided step rate with saturation at the arena edges.

## Interface
- `DEBOUNCE_MAX`, 500_000: consecutive stable cycles required before a debounced level changes.
- `ATTACK_CYCLES`, 25_000_000: duration of PUNCH and KICK, in cycles.
- `JUMP_CYCLES`, 50_000_000: duration of JUMP, in cycles.
- `STEP_DIV`, 1_000_000: cycles between position steps.
- `STEP_PX`, 2: pixels moved per step.
- `X_MIN`, 0 / `X_MAX`, 512 / `X_INIT`, 100: position limits and reset position. `X_MIN <= X_INIT <= X_MAX <= 1023`.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `btn_left`, `btn_right`, `btn_punch`, `btn_kick`, `btn_block`, `btn_jump` input 1 each: raw, asynchronous, active-high buttons.
- `player1_inputs` output 7: one-hot action vector.
  - [0] idle
  - [1] walk left
  - [2] walk right
  - [3] punch
  - [4] kick
  - [5] block
  - [6] jump
- `player1_x` output 10: left edge of the sprite, in pixels.
- `action_busy` output 1: high while in PUNCH, KICK or JUMP.

## Operation
- **Synchronizer:** each button passes through a 2-FF synchronizer.
- **Debounce:** one counter per button.
  - When the synchronized level differs from the debounced level, the counter increments.
  - When the counter reaches `DEBOUNCE_MAX`, the debounced level takes the new value and the counter clears.
  - Any cycle where the synchronized level equals the debounced level clears the counter.
- **Edge detect:** rising-edge pulses, one cycle wide, are derived from debounced punch, kick and jump. Left, right and block are level-sensitive.
- **FSM states:** IDLE, WALK_L, WALK_R, BLOCK, PUNCH, KICK, JUMP.
- **Free states (IDLE, WALK_L, WALK_R, BLOCK):** the next state is chosen every cycle by this priority:
  1. jump edge → JUMP
  2. punch edge → PUNCH
  3. kick edge → KICK
  4. block held → BLOCK
  5. left only → WALK_L
  6. right only → WALK_R
  7. otherwise (including left and right both held) → IDLE
- **Timed states (PUNCH, KICK, JUMP):**
  - A duration counter loads at entry.
  - The state exits after exactly `ATTACK_CYCLES` (PUNCH, KICK) or `JUMP_CYCLES` (JUMP) cycles in the state.
  - On exit, the free-state priority is applied in the same cycle.
  - All button edges arriving during a timed state are discarded, not queued. A button held through the exit is acted on only if it is level-sensitive.
- **Outputs:**
  - `player1_inputs` is the registered one-hot encoding of the state; exactly one bit is set at all times.
  - `action_busy` is registered and equals the OR of bits [3], [4] and [6].
- **Position:**
  - A free-running step counter counts 0..`STEP_DIV`-1 and produces a one-cycle step tick on wrap.
  - On a tick in WALK_L: `x = (x - STEP_PX < X_MIN) ? X_MIN : x - STEP_PX`. The compare is done in 11-bit signed arithmetic so no underflow wrap occurs.
  - On a tick in WALK_R: `x = min(x + STEP_PX, X_MAX)`, computed in 11 bits.
  - In every other state, `x` holds.
- **Reset:**
  - `player1_inputs` = 7'b0000001, `player1_x` = `X_INIT`, `action_busy` = 0, state = IDLE.
  - Synchronizers, debounced levels, debounce counters, duration counter and step counter are all 0.
  - A reset asserted mid-attack or mid-jump aborts the action immediately.

## Timing
- Raw button edge to debounced change: 2 synchronizer cycles plus `DEBOUNCE_MAX` cycles.
- Debounced change to state/`player1_inputs` change: 1 cycle, since the edge pulse and FSM transition take the same clock edge and the outputs register from next-state.
- Timed states: `player1_inputs` shows the action bit for exactly N cycles, then free-state behaviour resumes.
- Step tick to `player1_x` update: 1 cycle.
- A state change and a step tick in the same cycle use the pre-transition state for the move.

## Test plan
Bench parameters: `DEBOUNCE_MAX`=4, `ATTACK_CYCLES`=8, `JUMP_CYCLES`=16, `STEP_DIV`=4, `STEP_PX`=2, `X_MIN`=0, `X_MAX`=20, `X_INIT`=10.
- **Reset and bounce rejection:**
  - Release reset → `player1_inputs`=7'b0000001, `player1_x`=10, `action_busy`=0.
  - Toggle `btn_right` every 2 cycles for 40 cycles → outputs unchanged.
- **Walk right with saturation:** hold `btn_right` → bit [2] set 7 cycles after press. `player1_x` then rises 12, 14, … and saturates at 20. Release → IDLE; x stays 20.
- **Walk left with clamp:** from x=2 hold `btn_left` → x goes to 0 on the first tick and stays 0, with no wrap to 1022/1023.
- **Punch duration and edge discard:**
  - Press `btn_punch` → bit [3] set for exactly 8 cycles, `action_busy`=1.
  - A `btn_kick` press fully debounced inside the window is ignored.
  - With `btn_left` held at expiry → WALK_L.
- **Priority and conflicts:**
  - Jump and punch edges in the same cycle → JUMP for 16 cycles.
  - Left and right held together → IDLE.
  - Block held with left → BLOCK; x unchanged.
- **Reset mid-jump:** assert `rst` in JUMP cycle 5 → next cycle `player1_inputs`=7'b0000001, `player1_x`=10, `action_busy`=0.
